// File: rtl/pads_pkg.sv
// -----------------------------------------------------------------------------
// pads_pkg
//
// Shared definitions for the south bus pad bank:
//   - bus_state_e : sequencing states of the pad-bank FSM
//   - IE_OFF/OE_ON: tie values for pad cells that are output-only
//   - clog2       : elaboration-time ceiling log2 used to size counters
// -----------------------------------------------------------------------------
package pads_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for a core request
        WR   = 2'd1,   // driving address, data, strobe and write-enable
        RD   = 2'd2,   // driving address and strobe, data pads listening
        TURN = 2'd3    // one dead cycle: nothing driven, response pulsed
    } bus_state_e;

    // Tie values for pad cells that only ever drive (address, strobe, we).
    localparam logic IE_OFF = 1'b0;
    localparam logic OE_ON  = 1'b1;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage : pads_pkg

// File: rtl/hio18_gf28slp_iopad.sv
// -----------------------------------------------------------------------------
// HIO18_GF28SLP_IOPAD
//
// Behavioural model of the 1.8 V bidirectional pad cell. The real cell comes
// from the pad library; this model only reproduces its logical function so the
// pad ring can be elaborated and simulated.
//
// Ports:
//   PAD      inout  package pin
//   DATA_OUT input  value driven onto PAD when OE is high
//   OE       input  output enable
//   IE       input  input enable; DATA_IN reads 0 when low
//   OE18     input  1.8 V mode tie, no logical effect
//   DATA_IN  output value seen on PAD (gated by IE)
// -----------------------------------------------------------------------------
module HIO18_GF28SLP_IOPAD (
    inout  wire  PAD,
    input  logic DATA_OUT,
    input  logic OE,
    input  logic IE,
    input  logic OE18,
    output wire  DATA_IN
);

    assign PAD     = OE ? DATA_OUT : 1'bz;
    assign DATA_IN = IE ? PAD : 1'b0;

    // OE18 only selects the electrical mode of the real cell.
    wire unused_oe18 = OE18;

endmodule : HIO18_GF28SLP_IOPAD

// File: rtl/pads_bidir_bank.sv
// -----------------------------------------------------------------------------
// pads_bidir_bank
//
// A row of W identical bidirectional pad cells. Every bit has its own OE, IE
// and DATA_OUT so the same bank serves output-only buses (OE tied high, IE tied
// low) and the bidirectional data bus.
//
// Parameters:
//   W         number of pads in the bank
// Ports:
//   oe18      shared 1.8 V mode tie for all cells
//   oe        per-pad output enable
//   ie        per-pad input enable
//   data_out  per-pad drive value
//   data_in   per-pad sampled value (0 where ie is low)
//   pad       package pins
// -----------------------------------------------------------------------------
module pads_bidir_bank #(
    parameter int W = 1
) (
    input  logic         oe18,
    input  logic [W-1:0] oe,
    input  logic [W-1:0] ie,
    input  logic [W-1:0] data_out,
    output wire  [W-1:0] data_in,
    inout  wire  [W-1:0] pad
);

    for (genvar i = 0; i < W; i++) begin : g_pad
        HIO18_GF28SLP_IOPAD u_pad (
            .PAD      (pad[i]),
            .DATA_OUT (data_out[i]),
            .OE       (oe[i]),
            .IE       (ie[i]),
            .OE18     (oe18),
            .DATA_IN  (data_in[i])
        );
    end

endmodule : pads_bidir_bank

// File: rtl/pads_bus_io.sv
// -----------------------------------------------------------------------------
// pads_bus_io
//
// South bus pad bank: turns a core valid/ready request into a strobed external
// bus cycle on the package pins, with a registered address bus, a bidirectional
// data bus, strobe and write-enable. Every transfer ends with one TURN cycle in
// which nothing is driven, so the external device always gets a dead cycle
// before the next transfer.
//
// Parameters:
//   ADDR_W   number of address pads
//   DATA_W   number of bidirectional data pads
//   WR_CYC   cycles data is driven with strobe high on a write (>= 1)
//   RD_CYC   cycles strobe is held on a read before sampling (>= 1)
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   oe18_tie     tie to OE18 of every pad cell
//   req_valid    core request valid
//   req_ready    block can accept a request (IDLE and not in reset)
//   req_we       1 = write, 0 = read
//   req_addr     request address
//   req_wdata    write data
//   resp_valid   one-cycle completion pulse (during TURN)
//   resp_rdata   last captured read data
//   O_BUS_ADDR   address pads
//   IO_BUS_DATA  data pads
//   O_BUS_STB    strobe pad
//   O_BUS_WE     write-enable pad
// -----------------------------------------------------------------------------
module pads_bus_io
    import pads_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WR_CYC = 2,
    parameter int RD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oe18_tie,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output wire  [ADDR_W-1:0] O_BUS_ADDR,
    inout  wire  [DATA_W-1:0] IO_BUS_DATA,
    output wire               O_BUS_STB,
    output wire               O_BUS_WE
);

    localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int CNT_W   = clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);

    bus_state_e        state;
    bus_state_e        next_state;
    logic              accept;
    logic [CNT_W-1:0]  cnt;

    // Latched request. The direction of the transfer lives in the state
    // itself (WR vs RD), so no separate we register is kept.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    // Pad controls, all straight from flops so no req_* input reaches a pin
    // through logic.
    logic              data_oe;
    logic              data_ie;
    logic              stb;
    logic              we_pad;
    logic              resp_valid_q;

    wire  [DATA_W-1:0] data_in;
    wire  [ADDR_W-1:0] unused_addr_in;
    wire               unused_stb_in;
    wire               unused_we_in;

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_we ? WR : RD;
                end
            end
            WR:      if (cnt == '0) next_state = TURN;
            RD:      if (cnt == '0) next_state = TURN;
            TURN:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, request registers and pad-control flops
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, whatever the order of
    // the statements below.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every flop, including the data registers, because
        // they feed pad DATA_OUT and resp_rdata directly and must come up 0.
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            data_oe      <= 1'b0;
            data_ie      <= 1'b0;
            stb          <= 1'b0;
            we_pad       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state <= next_state;

            // The counter is loaded only on accept and holds at zero, so it
            // never wraps even if a state lingers.
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= req_we ? WR_LOAD : RD_LOAD;
            end else if (((state == WR) || (state == RD)) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            // Sample the bus on the last strobe cycle of a read.
            if ((state == RD) && (cnt == '0)) begin
                rdata_q <= data_in;
            end

            // Pad controls are decoded from next_state so that, once
            // registered, they line up with the state they belong to.
            stb          <= (next_state == WR) || (next_state == RD);
            we_pad       <= (next_state == WR);
            data_oe      <= (next_state == WR);
            data_ie      <= (next_state == RD);
            resp_valid_q <= (next_state == TURN);
        end
    end

    // -------------------------------------------------------------------------
    // Pad banks
    // -------------------------------------------------------------------------
    pads_bidir_bank #(.W(ADDR_W)) u_addr_bank (
        .oe18     (oe18_tie),
        .oe       ({ADDR_W{OE_ON}}),
        .ie       ({ADDR_W{IE_OFF}}),
        .data_out (addr_q),
        .data_in  (unused_addr_in),
        .pad      (O_BUS_ADDR)
    );

    pads_bidir_bank #(.W(DATA_W)) u_data_bank (
        .oe18     (oe18_tie),
        .oe       ({DATA_W{data_oe}}),
        .ie       ({DATA_W{data_ie}}),
        .data_out (wdata_q),
        .data_in  (data_in),
        .pad      (IO_BUS_DATA)
    );

    pads_bidir_bank #(.W(1)) u_stb_bank (
        .oe18     (oe18_tie),
        .oe       (OE_ON),
        .ie       (IE_OFF),
        .data_out (stb),
        .data_in  (unused_stb_in),
        .pad      (O_BUS_STB)
    );

    pads_bidir_bank #(.W(1)) u_we_bank (
        .oe18     (oe18_tie),
        .oe       (OE_ON),
        .ie       (IE_OFF),
        .data_out (we_pad),
        .data_in  (unused_we_in),
        .pad      (O_BUS_WE)
    );

endmodule : pads_bus_io

// File: tb/tb_pads_bus_io.sv
// -----------------------------------------------------------------------------
// tb_pads_bus_io
//
// Two instances: dut0 with default parameters, dut1 with ADDR_W=24, DATA_W=32,
// WR_CYC=1, RD_CYC=4. Expected responses are queued when a request is driven
// and popped when resp_valid appears. A simple external device drives the data
// bus during reads; a monitor flags any cycle in which both sides drive.
// -----------------------------------------------------------------------------
module tb_pads_bus_io;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- dut0 (defaults) ----------------
    logic        req_valid0, req_we0, req_ready0, resp_valid0;
    logic [15:0] req_addr0, req_wdata0, resp_rdata0;
    wire  [15:0] addr_pad0;
    wire  [15:0] data_pad0;
    wire         stb0, we0;
    logic        ext_en0;
    logic [15:0] ext_data0;
    assign data_pad0 = ext_en0 ? ext_data0 : 16'hzzzz;

    pads_bus_io dut0 (
        .clk         (clk),
        .rst         (rst),
        .oe18_tie    (1'b1),
        .req_valid   (req_valid0),
        .req_ready   (req_ready0),
        .req_we      (req_we0),
        .req_addr    (req_addr0),
        .req_wdata   (req_wdata0),
        .resp_valid  (resp_valid0),
        .resp_rdata  (resp_rdata0),
        .O_BUS_ADDR  (addr_pad0),
        .IO_BUS_DATA (data_pad0),
        .O_BUS_STB   (stb0),
        .O_BUS_WE    (we0)
    );

    // ---------------- dut1 (parameter sweep) ----------------
    logic        req_valid1, req_we1, req_ready1, resp_valid1;
    logic [23:0] req_addr1;
    logic [31:0] req_wdata1, resp_rdata1;
    wire  [23:0] addr_pad1;
    wire  [31:0] data_pad1;
    wire         stb1, we1;
    logic        ext_en1;
    logic [31:0] ext_data1;
    assign data_pad1 = ext_en1 ? ext_data1 : 32'hzzzz_zzzz;

    pads_bus_io #(.ADDR_W(24), .DATA_W(32), .WR_CYC(1), .RD_CYC(4)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .oe18_tie    (1'b1),
        .req_valid   (req_valid1),
        .req_ready   (req_ready1),
        .req_we      (req_we1),
        .req_addr    (req_addr1),
        .req_wdata   (req_wdata1),
        .resp_valid  (resp_valid1),
        .resp_rdata  (resp_rdata1),
        .O_BUS_ADDR  (addr_pad1),
        .IO_BUS_DATA (data_pad1),
        .O_BUS_STB   (stb1),
        .O_BUS_WE    (we1)
    );

    // ---------------- scoreboard and checking ----------------
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic [31:0] last_rd0, last_rd1;
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response and bus-contention monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid0) begin
                if (sb0.size() == 0) check("resp0_spurious", resp_valid0, 1'b0);
                else                 check("sb_rdata0", resp_rdata0, sb0.pop_front());
            end
            if (resp_valid1) begin
                if (sb1.size() == 0) check("resp1_spurious", resp_valid1, 1'b0);
                else                 check("sb_rdata1", resp_rdata1, sb1.pop_front());
            end
            if (ext_en0) check("contention0", dut0.data_oe, 1'b0);
            if (ext_en1) check("contention1", dut1.data_oe, 1'b0);
        end
    end

    // Present a request on dut0, wait (bounded) for ready, queue the expected
    // response and let the accepting edge pass. req_valid drops afterwards.
    task automatic start0(input logic we, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        req_we0    = we;
        req_addr0  = a;
        req_wdata0 = d;
        req_valid0 = 1'b1;
        while (!req_ready0 && n < 20) begin
            tick();
            n++;
        end
        check("ready0_wait", req_ready0, 1'b1);
        if (we) sb0.push_back(last_rd0);
        else begin
            sb0.push_back({16'h0, ext_data0});
            last_rd0 = {16'h0, ext_data0};
        end
        tick();
        req_valid0 = 1'b0;
    endtask

    task automatic wait_resp0();
        int n;
        n = 0;
        while (!resp_valid0 && n < 20) begin
            tick();
            n++;
        end
        check("resp0_wait", resp_valid0, 1'b1);
    endtask

    // One complete transfer on dut1 with accept-to-next-ready latency check.
    task automatic txn1(input logic we, input logic [23:0] a, input logic [31:0] d,
                        input int exp_lat);
        int n;
        n = 0;
        req_we1    = we;
        req_addr1  = a;
        req_wdata1 = d;
        if (!we) begin
            ext_data1 = d;
            ext_en1   = 1'b1;
        end
        req_valid1 = 1'b1;
        while (!req_ready1 && n < 20) begin
            tick();
            n++;
        end
        check("ready1_wait", req_ready1, 1'b1);
        if (we) sb1.push_back(last_rd1);
        else begin
            sb1.push_back(d);
            last_rd1 = d;
        end
        tick();
        req_valid1 = 1'b0;
        check("sw_addr", addr_pad1, a);
        check("sw_stb", stb1, 1'b1);
        if (we) check("sw_wdata", data_pad1, d);
        else    check("sw_ie", dut1.data_ie, 1'b1);
        n = 0;
        while (!req_ready1 && n < 20) begin
            tick();
            n++;
        end
        check(we ? "sw_wr_latency" : "sw_rd_latency", n + 1, exp_lat);
        ext_en1 = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saw_turn;

        rst        = 1'b1;
        ext_en0    = 1'b0;
        ext_data0  = '0;
        ext_en1    = 1'b0;
        ext_data1  = '0;
        last_rd0   = '0;
        last_rd1   = '0;
        req_valid0 = 1'b1;
        req_we0    = 1'b1;
        req_addr0  = 16'h5555;
        req_wdata0 = 16'h1111;
        req_valid1 = 1'b0;
        req_we1    = 1'b0;
        req_addr1  = '0;
        req_wdata1 = '0;

        // ---- reset held 3 cycles with a request pending ----
        repeat (3) tick();
        check("rst_stb",   stb0, 1'b0);
        check("rst_we",    we0, 1'b0);
        check("rst_oe",    dut0.data_oe, 1'b0);
        check("rst_addr",  addr_pad0, 16'h0000);
        check("rst_ready", req_ready0, 1'b0);
        check("rst_resp",  resp_valid0, 1'b0);
        check("rst_rdata", resp_rdata0, 16'h0000);
        rst        = 1'b0;
        req_valid0 = 1'b0;
        #1;
        check("ready_after_rst", req_ready0, 1'b1);
        tick();

        // ---- single write ----
        start0(1'b1, 16'h1234, 16'hBEEF);
        for (int c = 0; c < 2; c++) begin
            check("wr_stb",  stb0, 1'b1);
            check("wr_we",   we0, 1'b1);
            check("wr_data", data_pad0, 16'hBEEF);
            check("wr_addr", addr_pad0, 16'h1234);
            check("wr_resp", resp_valid0, 1'b0);
            tick();
        end
        check("wr_turn_stb",   stb0, 1'b0);
        check("wr_turn_oe",    dut0.data_oe, 1'b0);
        check("wr_turn_resp",  resp_valid0, 1'b1);
        check("wr_turn_ready", req_ready0, 1'b0);
        tick();
        check("wr_idle_ready", req_ready0, 1'b1);
        check("wr_idle_resp",  resp_valid0, 1'b0);

        // ---- single read ----
        ext_data0 = 16'hA5A5;
        ext_en0   = 1'b1;
        start0(1'b0, 16'h00C3, 16'h0000);
        for (int c = 0; c < 2; c++) begin
            check("rd_stb", stb0, 1'b1);
            check("rd_we",  we0, 1'b0);
            check("rd_ie",  dut0.data_ie, 1'b1);
            check("rd_oe",  dut0.data_oe, 1'b0);
            tick();
        end
        check("rd_turn_resp",  resp_valid0, 1'b1);
        check("rd_turn_rdata", resp_rdata0, 16'hA5A5);
        check("rd_turn_ie",    dut0.data_ie, 1'b0);
        check("rd_turn_stb",   stb0, 1'b0);
        tick();
        ext_en0 = 1'b0;

        // ---- back-to-back write then read, req_valid held high ----
        req_we0    = 1'b1;
        req_addr0  = 16'h0F0F;
        req_wdata0 = 16'h3C3C;
        req_valid0 = 1'b1;
        n = 0;
        while (!req_ready0 && n < 20) begin
            tick();
            n++;
        end
        check("b2b_ready", req_ready0, 1'b1);
        sb0.push_back(last_rd0);
        tick();
        req_we0   = 1'b0;
        req_addr0 = 16'hF0F0;
        ext_data0 = 16'h6996;
        n         = 0;
        saw_turn  = 0;
        while (!req_ready0 && n < 20) begin
            tick();
            n++;
            if (n == 1) check("b2b_addr_hold", addr_pad0, 16'h0F0F);
            if (resp_valid0) begin
                saw_turn++;
                check("b2b_turn_stb", stb0, 1'b0);
                check("b2b_turn_oe",  dut0.data_oe, 1'b0);
            end
        end
        ext_en0 = 1'b1;
        sb0.push_back({16'h0, ext_data0});
        last_rd0 = {16'h0, ext_data0};
        tick();
        n++;
        req_valid0 = 1'b0;
        check("b2b_gap",       n, 4);
        check("b2b_turn_seen", saw_turn, 1);
        check("b2b_rd_addr",   addr_pad0, 16'hF0F0);
        wait_resp0();
        check("b2b_rd_rdata",  resp_rdata0, 16'h6996);
        tick();
        ext_en0 = 1'b0;

        // ---- reset in the second WR cycle ----
        start0(1'b1, 16'h7777, 16'h8888);
        tick();
        check("mid_wr2_stb", stb0, 1'b1);
        rst = 1'b1;
        sb0.delete();
        last_rd0 = '0;
        tick();
        check("mid_rst_stb",   stb0, 1'b0);
        check("mid_rst_we",    we0, 1'b0);
        check("mid_rst_oe",    dut0.data_oe, 1'b0);
        check("mid_rst_resp",  resp_valid0, 1'b0);
        check("mid_rst_rdata", resp_rdata0, 16'h0000);
        rst = 1'b0;
        tick();
        check("mid_rst_no_resp", resp_valid0, 1'b0);
        ext_data0 = 16'h5A3C;
        ext_en0   = 1'b1;
        start0(1'b0, 16'h4242, 16'h0000);
        wait_resp0();
        check("post_rst_rdata", resp_rdata0, 16'h5A3C);
        tick();
        ext_en0 = 1'b0;

        // ---- parameter sweep on dut1 ----
        txn1(1'b1, 24'hFFFFFF, 32'hFFFF_FFFF, 3);
        txn1(1'b0, 24'hFFFFFF, 32'hFFFF_FFFF, 6);
        txn1(1'b1, 24'h000000, 32'h0000_0000, 3);
        txn1(1'b0, 24'hA5A5A5, 32'h5A5A_A5A5, 6);
        txn1(1'b1, 24'h5A5A5A, 32'hA5A5_5A5A, 3);
        txn1(1'b0, 24'h000000, 32'h0000_0000, 6);
        txn1(1'b0, 24'h123456, 32'h8000_0001, 6);
        txn1(1'b1, 24'h654321, 32'h7FFF_FFFE, 3);
        check("sw_rdata_hold", resp_rdata1, 32'h8000_0001);

        repeat (4) tick();
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_pads_bus_io
